// File: rtl/isqrt_fsm.sv
// isqrt_fsm: shared integer square-root responder, y = floor(sqrt(x)).
//
// Computes the result one digit at a time. Each digit consumes two radicand bits.
// R digits are computed per clock. The unit is multi-cycle and not pipelined.
// Requests that arrive while it is busy are dropped, and ovf_o records that this happened.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   x_vld_i  one-cycle request strobe; x_i is sampled on the same edge
//   x_i      unsigned radicand, W bits
//   y_vld_o  one-cycle result-valid pulse (registered)
//   y_o      floor(sqrt(x)), W/2 bits, held until the next y_vld_o
//   busy_o   high while computing; requests are ignored then
//   ovf_o    sticky flag: a request arrived while busy and was dropped
module isqrt_fsm #(
  parameter int unsigned W = 32,
  parameter int unsigned R = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             x_vld_i,
  input  logic [W-1:0]     x_i,
  output logic             y_vld_o,
  output logic [W/2-1:0]   y_o,
  output logic             busy_o,
  output logic             ovf_o
);

  localparam int unsigned HW = W / 2;       // result width
  localparam int unsigned RW = HW + 2;      // remainder / trial width, cannot overflow
  localparam int unsigned CW = $clog2(HW + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q;
  logic [W-1:0]    rad_q;
  logic [RW-1:0]   rem_q;
  logic [HW-1:0]   root_q;
  logic [CW-1:0]   cnt_q;
  logic [HW-1:0]   y_q;
  logic            y_vld_q;
  logic            busy_q;
  logic            ovf_q;

  // Next values after R unrolled iterations
  logic [W-1:0]    rad_d;
  logic [RW-1:0]   rem_d;
  logic [HW-1:0]   root_d;
  logic [CW-1:0]   cnt_d;
  logic            last_iter;

  // Per-iteration temporaries
  logic [RW-1:0]   rem_sh;
  logic [RW-1:0]   trial;

  always_comb begin
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    rem_sh = '0;
    trial  = '0;
    for (int i = 0; i < int'(R); i++) begin
      // Bring down the next two radicand bits
      rem_sh = (rem_d << 2) | RW'(rad_d[W-1:W-2]);
      rad_d  = rad_d << 2;
      trial  = (RW'(root_d) << 2) | RW'(1);
      if (rem_sh >= trial) begin
        rem_d  = rem_sh - trial;
        root_d = (root_d << 1) | HW'(1);
      end else begin
        rem_d  = rem_sh;
        root_d = root_d << 1;
      end
    end
  end

  always_comb begin
    cnt_d     = cnt_q + CW'(R);
    last_iter = (cnt_d == CW'(HW));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      y_vld_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      y_vld_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (x_vld_i) begin
            rad_q   <= x_i;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            state_q <= StCalc;
            busy_q  <= 1'b1;
          end
        end
        StCalc: begin
          rad_q  <= rad_d;
          rem_q  <= rem_d;
          root_q <= root_d;
          cnt_q  <= cnt_d;
          // Requests during a computation are dropped; only the flag records them
          if (x_vld_i) begin
            ovf_q <= 1'b1;
          end
          if (last_iter) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            y_vld_q <= 1'b1;
            y_q     <= root_d;
          end
        end
        StDone: begin
          // The result cycle also accepts a new request, so requests can run back-to-back
          if (x_vld_i) begin
            rad_q   <= x_i;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            state_q <= StCalc;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign y_vld_o = y_vld_q;
  assign y_o     = y_q;
  assign busy_o  = busy_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_isqrt_fsm.sv
// Bench for isqrt_fsm. It drives two instances, one with R=1 and one with R=2.
// Each result is compared with a binary-search integer square root.
module tb_isqrt_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_vld, b_vld;
  logic [31:0] a_x, b_x;
  logic        a_yv, b_yv;
  logic [15:0] a_y, b_y;
  logic        a_busy, b_busy, a_ovf, b_ovf;

  int checks = 0;
  int errors = 0;

  isqrt_fsm #(.W(32), .R(1)) u_dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .x_vld_i(a_vld),
    .x_i    (a_x),
    .y_vld_o(a_yv),
    .y_o    (a_y),
    .busy_o (a_busy),
    .ovf_o  (a_ovf)
  );

  isqrt_fsm #(.W(32), .R(2)) u_dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .x_vld_i(b_vld),
    .x_i    (b_x),
    .y_vld_o(b_yv),
    .y_o    (b_y),
    .busy_o (b_busy),
    .ovf_o  (b_ovf)
  );

  // Largest r with r*r <= v
  function automatic longint unsigned ref_isqrt(input longint unsigned v);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic yv(input int sel);
    return (sel == 0) ? a_yv : b_yv;
  endfunction

  function automatic logic [15:0] yo(input int sel);
    return (sel == 0) ? a_y : b_y;
  endfunction

  // Issue one request. Check the latency in cycles and the returned value.
  // The task returns at the negedge in the result cycle.
  task automatic run(input int sel, input logic [31:0] v, input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    if (sel == 0) begin a_vld = 1'b1; a_x = v; end
    else begin b_vld = 1'b1; b_x = v; end
    @(negedge clk);
    a_vld = 1'b0;
    b_vld = 1'b0;
    a_x   = $urandom;  // x is only sampled on the accept edge
    b_x   = $urandom;
    lat   = 1;
    while (!yv(sel) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " y"}, yo(sel), ref_isqrt(v));
  endtask

  initial begin
    int lat;
    int busy_low;
    int extra;
    logic [31:0] v;

    rst_n = 1'b0;
    a_vld = 1'b0; b_vld = 1'b0;
    a_x   = '0;   b_x   = '0;
    #1;
    chk("reset a_yv", a_yv, 0);
    chk("reset a_y", a_y, 0);
    chk("reset a_busy", a_busy, 0);
    chk("reset a_ovf", a_ovf, 0);
    chk("reset b_busy", b_busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1 and Test 2
    run(0, 32'd0, 17, "x=0");
    run(0, 32'd1, 17, "x=1");
    chk("busy low in done", a_busy, 0);
    run(0, 32'd16, 17, "x=16");
    run(0, 32'd15, 17, "x=15");
    run(0, 32'd1_000_000, 17, "x=1e6");
    // Test 3: values at the top of the input range
    run(0, 32'hFFFF_FFFF, 17, "x=max");
    run(0, 32'hFFFE_0001, 17, "x=fffe0001");
    run(0, 32'hFFFE_0000, 17, "x=fffe0000");

    // Test 4: back-to-back request accepted in the result cycle
    run(0, 32'd100, 17, "b2b first");
    a_vld = 1'b1;
    a_x   = 32'd9;
    @(negedge clk);
    a_vld    = 1'b0;
    lat      = 1;
    busy_low = 0;
    while (!a_yv && lat < 40) begin
      if (!a_busy) busy_low++;
      @(negedge clk);
      lat++;
    end
    chk("b2b second latency", lat, 17);
    chk("b2b second y", a_y, 3);
    chk("b2b busy gaps", busy_low, 0);

    // Test 5: a request during the computation is dropped and sets ovf
    chk("ovf clear before overlap", a_ovf, 0);
    @(negedge clk);
    a_vld = 1'b1;
    a_x   = 32'd49;
    @(negedge clk);
    a_vld = 1'b0;
    lat   = 1;
    while (!a_yv && lat < 40) begin
      if (lat == 5) begin a_vld = 1'b1; a_x = 32'd4; end
      @(negedge clk);
      a_vld = 1'b0;
      lat++;
    end
    chk("overlap latency", lat, 17);
    chk("overlap y", a_y, 7);
    chk("overlap ovf", a_ovf, 1);
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (a_yv) extra++;
    end
    chk("overlap no second y_vld", extra, 0);
    chk("ovf sticky", a_ovf, 1);
    chk("y held in idle", a_y, 7);

    // Test 6: reset during the computation abandons it
    @(negedge clk);
    a_vld = 1'b1;
    a_x   = 32'd12345;
    @(negedge clk);
    a_vld = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy mid calc", a_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async rst y_vld", a_yv, 0);
    chk("async rst y", a_y, 0);
    chk("async rst busy", a_busy, 0);
    chk("async rst ovf", a_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_yv) extra++;
    end
    chk("abandoned no y_vld", extra, 0);
    run(0, 32'd81, 17, "x=81 after reset");

    // Tests 2 and 3 repeated on the R=2 instance
    run(1, 32'd16, 9, "R2 x=16");
    run(1, 32'd15, 9, "R2 x=15");
    run(1, 32'd1_000_000, 9, "R2 x=1e6");
    run(1, 32'hFFFF_FFFF, 9, "R2 x=max");
    run(1, 32'hFFFE_0001, 9, "R2 x=fffe0001");
    run(1, 32'hFFFE_0000, 9, "R2 x=fffe0000");

    // Random radicands for both instances
    for (int i = 0; i < 10; i++) begin
      v = (i < 4) ? 32'($urandom_range(0, 5000)) : 32'($urandom);
      run(0, v, 17, "rand R1");
      run(1, v, 9, "rand R2");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
